// File: rtl/gate_response_checker.sv
// Gate response checker: captures applied operands and observed gate outputs,
// compares them against the ideal gate functions and summarises a run of NUM_VEC vectors.
module gate_response_checker #(
  parameter int NUM_VEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sample_valid,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       in,
  input  logic       y_not,
  input  logic [1:0] y_and,
  input  logic [1:0] y_or,
  input  logic [1:0] y_nand,
  input  logic [1:0] y_nor,
  input  logic [1:0] y_xor,
  input  logic [1:0] y_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic [7:0] vec_count,
  output logic [7:0] first_fail_idx,
  output logic [6:0] first_fail_mask,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(NUM_VEC);

  state_t     state;
  logic       s1_valid;
  logic [7:0] acc_cnt;
  logic [1:0] c_a, c_b;
  logic       c_in, c_not;
  logic [1:0] c_and, c_or, c_nand, c_nor, c_xor, c_xnor;
  logic [6:0] fail_mask;
  logic       fail;
  logic       accept;
  logic       final_cmp;

  assign state_dbg = state;

  // Stage 2 compare operates purely on the captured copy of the vector.
  always_comb begin
    fail_mask    = '0;
    fail_mask[0] = c_not  != ~c_in;
    fail_mask[1] = c_and  != (c_a & c_b);
    fail_mask[2] = c_or   != (c_a | c_b);
    fail_mask[3] = c_nand != ~(c_a & c_b);
    fail_mask[4] = c_nor  != ~(c_a | c_b);
    fail_mask[5] = c_xor  != (c_a ^ c_b);
    fail_mask[6] = c_xnor != ~(c_a ^ c_b);
    fail         = |fail_mask;
  end

  assign accept    = sample_valid && (acc_cnt < LAST);
  assign final_cmp = (vec_count + 8'd1) == LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      s1_valid        <= 1'b0;
      acc_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
      c_a <= '0; c_b <= '0; c_in <= 1'b0; c_not <= 1'b0;
      c_and <= '0; c_or <= '0; c_nand <= '0; c_nor <= '0; c_xor <= '0; c_xnor <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          s1_valid <= 1'b0;
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            acc_cnt         <= '0;
            err_count       <= '0;
            vec_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_mask <= '0;
          end
        end
        RUN: begin
          s1_valid <= accept;
          if (accept) begin
            acc_cnt <= acc_cnt + 8'd1;
            c_a     <= a;
            c_b     <= b;
            c_in    <= in;
            c_not   <= y_not;
            c_and   <= y_and;
            c_or    <= y_or;
            c_nand  <= y_nand;
            c_nor   <= y_nor;
            c_xor   <= y_xor;
            c_xnor  <= y_xnor;
          end
          if (s1_valid) begin
            vec_count <= vec_count + 8'd1;
            if (fail) begin
              mismatch <= 1'b1;
              if (err_count != 8'hff) err_count <= err_count + 8'd1;
              if (err_count == 8'd0) begin
                first_fail_idx  <= vec_count;
                first_fail_mask <= fail_mask;
              end
            end
            if (final_cmp) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 8'd0) && !fail;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: NUM_VEC=4 main instance plus a NUM_VEC=1 boundary instance.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, sample_valid;
  logic [1:0] a, b;
  logic       in, y_not;
  logic [1:0] y_and, y_or, y_nand, y_nor, y_xor, y_xnor;

  logic       busy, done, pass, mismatch;
  logic [7:0] err_count, vec_count, first_fail_idx;
  logic [6:0] first_fail_mask;
  logic [1:0] state_dbg;

  logic       busy_1, done_1, pass_1, mismatch_1;
  logic [7:0] err_count_1, vec_count_1, first_fail_idx_1;
  logic [6:0] first_fail_mask_1;
  logic [1:0] state_dbg_1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VEC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .in(in), .y_not(y_not), .y_and(y_and), .y_or(y_or),
    .y_nand(y_nand), .y_nor(y_nor), .y_xor(y_xor), .y_xnor(y_xnor),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .vec_count(vec_count), .first_fail_idx(first_fail_idx),
    .first_fail_mask(first_fail_mask), .state_dbg(state_dbg)
  );

  gate_response_checker #(.NUM_VEC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .in(in), .y_not(y_not), .y_and(y_and), .y_or(y_or),
    .y_nand(y_nand), .y_nor(y_nor), .y_xor(y_xor), .y_xnor(y_xnor),
    .busy(busy_1), .done(done_1), .pass(pass_1), .mismatch(mismatch_1),
    .err_count(err_count_1), .vec_count(vec_count_1), .first_fail_idx(first_fail_idx_1),
    .first_fail_mask(first_fail_mask_1), .state_dbg(state_dbg_1)
  );

  // ---------------- clock / reset ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    a = '0; b = '0; in = 1'b0; y_not = 1'b0;
    y_and = '0; y_or = '0; y_nand = '0; y_nor = '0; y_xor = '0; y_xnor = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Vector i uses a=b=i[1:0], in=i[0]; each set bit of f flips bit0 of that gate's output.
  task automatic drive_vec(input int i, input logic [6:0] f);
    a = i[1:0];
    b = i[1:0];
    in = i[0];
    y_not  = ~in ^ f[0];
    y_and  = (a & b)    ^ {1'b0, f[1]};
    y_or   = (a | b)    ^ {1'b0, f[2]};
    y_nand = ~(a & b)   ^ {1'b0, f[3]};
    y_nor  = ~(a | b)   ^ {1'b0, f[4]};
    y_xor  = (a ^ b)    ^ {1'b0, f[5]};
    y_xnor = ~(a ^ b)   ^ {1'b0, f[6]};
    sample_valid = 1'b1;
  endtask

  // Four back-to-back vectors then one idle edge for the last compare.
  task automatic feed4(input logic [27:0] faults, output int mm, output logic done_early);
    mm = 0;
    for (int i = 0; i < 4; i++) begin
      drive_vec(i, faults[i*7 +: 7]);
      tick();
      mm += int'(mismatch);
    end
    sample_valid = 1'b0;
    done_early = done;
    tick();
    mm += int'(mismatch);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else passed++;
    checks++; if ({busy, done, pass, mismatch} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, mismatch}); else passed++;
    checks++; if ({err_count, vec_count, first_fail_idx, first_fail_mask} !== 31'b0) $display("FAIL reset_counts: got %h expected 0", {err_count, vec_count, first_fail_idx, first_fail_mask}); else passed++;
    checks++; if ({busy_1, done_1, pass_1, vec_count_1} !== 11'b0) $display("FAIL reset_dut1: got %h expected 0", {busy_1, done_1, pass_1, vec_count_1}); else passed++;
  endtask

  task automatic test_clean_run;
    int mm; logic de;
    pulse_start();
    checks++; if (busy !== 1'b1 || state_dbg !== 2'd1) $display("FAIL clean_start: busy=%b state=%0d expected busy=1 state=1", busy, state_dbg); else passed++;
    feed4(28'h0, mm, de);
    checks++; if (de !== 1'b0) $display("FAIL clean_done_early: got %b expected 0", de); else passed++;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || state_dbg !== 2'd2) $display("FAIL clean_done: done=%b busy=%b state=%0d expected 1 0 2", done, busy, state_dbg); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL clean_pass: got %b expected 1", pass); else passed++;
    checks++; if (err_count !== 8'd0 || vec_count !== 8'd4) $display("FAIL clean_counts: err=%0d vec=%0d expected 0 4", err_count, vec_count); else passed++;
    checks++; if (mm !== 0) $display("FAIL clean_mismatch: got %0d pulses expected 0", mm); else passed++;
  endtask

  task automatic test_single_fault;
    int mm; logic de;
    pulse_start();
    feed4(28'h0008000, mm, de);  // vector 2, AND gate
    checks++; if (mm !== 1) $display("FAIL single_pulses: got %0d expected 1", mm); else passed++;
    checks++; if (err_count !== 8'd1) $display("FAIL single_err: got %0d expected 1", err_count); else passed++;
    checks++; if (first_fail_idx !== 8'd2) $display("FAIL single_idx: got %0d expected 2", first_fail_idx); else passed++;
    checks++; if (first_fail_mask !== 7'b0000010) $display("FAIL single_mask: got %b expected 0000010", first_fail_mask); else passed++;
    checks++; if (pass !== 1'b0 || done !== 1'b1) $display("FAIL single_pass: pass=%b done=%b expected 0 1", pass, done); else passed++;
  endtask

  task automatic test_two_faults;
    int mm; logic de;
    pulse_start();
    feed4(28'h4000080, mm, de);  // vector 1 NOT, vector 3 XOR
    checks++; if (err_count !== 8'd2 || mm !== 2) $display("FAIL two_err: err=%0d pulses=%0d expected 2 2", err_count, mm); else passed++;
    checks++; if (first_fail_idx !== 8'd1) $display("FAIL two_idx: got %0d expected 1", first_fail_idx); else passed++;
    checks++; if (first_fail_mask !== 7'b0000001) $display("FAIL two_mask: got %b expected 0000001", first_fail_mask); else passed++;
    checks++; if (pass !== 1'b0 || vec_count !== 8'd4) $display("FAIL two_pass: pass=%b vec=%0d expected 0 4", pass, vec_count); else passed++;
  endtask

  task automatic test_restart;
    int mm; logic de;
    pulse_start();  // from DONE with errors recorded
    checks++; if ({err_count, vec_count, first_fail_idx, first_fail_mask} !== 31'b0) $display("FAIL restart_clear: got %h expected 0", {err_count, vec_count, first_fail_idx, first_fail_mask}); else passed++;
    checks++; if ({busy, done, pass} !== 3'b100) $display("FAIL restart_flags: got %b expected 100", {busy, done, pass}); else passed++;
    feed4(28'h0, mm, de);
    checks++; if (pass !== 1'b1 || err_count !== 8'd0 || done !== 1'b1) $display("FAIL restart_run: pass=%b err=%0d done=%b expected 1 0 1", pass, err_count, done); else passed++;
  endtask

  task automatic test_ignored;
    do_reset();
    drive_vec(0, 7'h7f);
    tick();
    sample_valid = 1'b0;
    tick();
    checks++; if (state_dbg !== 2'd0 || vec_count !== 8'd0 || mismatch !== 1'b0) $display("FAIL idle_sample: state=%0d vec=%0d mm=%b expected 0 0 0", state_dbg, vec_count, mismatch); else passed++;
    pulse_start();
    drive_vec(0, 7'h00); tick();
    drive_vec(1, 7'h00); start = 1'b1; tick(); start = 1'b0;
    checks++; if (vec_count !== 8'd1 || busy !== 1'b1 || state_dbg !== 2'd1) $display("FAIL run_start_ignored: vec=%0d busy=%b state=%0d expected 1 1 1", vec_count, busy, state_dbg); else passed++;
    drive_vec(2, 7'h00); tick();
    drive_vec(3, 7'h00); tick();
    drive_vec(0, 7'h7f); tick();  // 5th sample, must not be accepted
    checks++; if (vec_count !== 8'd4 || done !== 1'b1 || mismatch !== 1'b0) $display("FAIL fifth_sample: vec=%0d done=%b mm=%b expected 4 1 0", vec_count, done, mismatch); else passed++;
    tick();  // sample_valid still high in DONE
    sample_valid = 1'b0;
    checks++; if (vec_count !== 8'd4 || err_count !== 8'd0 || pass !== 1'b1 || mismatch !== 1'b0) $display("FAIL done_sample: vec=%0d err=%0d pass=%b mm=%b expected 4 0 1 0", vec_count, err_count, pass, mismatch); else passed++;
  endtask

  task automatic test_reset_midrun;
    int mm; logic de;
    pulse_start();
    drive_vec(0, 7'h00); tick();
    drive_vec(1, 7'h7f); tick();  // faulty vector in flight when reset hits
    drive_vec(2, 7'h00); rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0; sample_valid = 1'b0;
    checks++; if (state_dbg !== 2'd0 || {busy, done, pass, mismatch} !== 4'b0) $display("FAIL midrun_flags: state=%0d flags=%b expected 0 0000", state_dbg, {busy, done, pass, mismatch}); else passed++;
    checks++; if ({err_count, vec_count, first_fail_idx, first_fail_mask} !== 31'b0) $display("FAIL midrun_counts: got %h expected 0", {err_count, vec_count, first_fail_idx, first_fail_mask}); else passed++;
    tick();
    checks++; if (mismatch !== 1'b0 || err_count !== 8'd0 || vec_count !== 8'd0) $display("FAIL midrun_inflight: mm=%b err=%0d vec=%0d expected 0 0 0", mismatch, err_count, vec_count); else passed++;
    pulse_start();
    feed4(28'h0, mm, de);
    checks++; if (pass !== 1'b1 || vec_count !== 8'd4 || mm !== 0) $display("FAIL midrun_rerun: pass=%b vec=%0d pulses=%0d expected 1 4 0", pass, vec_count, mm); else passed++;
  endtask

  task automatic test_boundary_one;
    do_reset();
    pulse_start();
    checks++; if (busy_1 !== 1'b1) $display("FAIL one_busy: got %b expected 1", busy_1); else passed++;
    drive_vec(3, 7'h00); tick();
    sample_valid = 1'b0;
    checks++; if (done_1 !== 1'b0 || vec_count_1 !== 8'd0) $display("FAIL one_capture: done=%b vec=%0d expected 0 0", done_1, vec_count_1); else passed++;
    tick();
    checks++; if (done_1 !== 1'b1 || pass_1 !== 1'b1 || busy_1 !== 1'b0) $display("FAIL one_done: done=%b pass=%b busy=%b expected 1 1 0", done_1, pass_1, busy_1); else passed++;
    checks++; if (vec_count_1 !== 8'd1 || state_dbg_1 !== 2'd2) $display("FAIL one_vec: vec=%0d state=%0d expected 1 2", vec_count_1, state_dbg_1); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_clean_run();
    test_single_fault();
    test_two_faults();
    test_restart();
    test_ignored();
    test_reset_midrun();
    test_boundary_one();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
